// File: rtl/keycode_move_ctrl.sv
// Keyboard-to-move-request controller: one registered keycode feeds a per-player
// hold/auto-repeat FSM whose events land in a one-entry valid/ready output slot.

module keycode_move_player #(
  parameter logic [3:0][7:0] KEYS     = '0,
  parameter logic [5:0]      HOLD_LIM = 6'd19,
  parameter logic [5:0]      REP_LIM  = 6'd7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] k_q,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       ready,
  output logic       valid,
  output logic [1:0] dir
);
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_t;

  state_t     state;
  logic [5:0] cnt;
  logic [1:0] cur_dir;
  logic       hit;
  logic [1:0] kdir;
  logic [5:0] lim;
  logic       ev;

  // KEYS is indexed by direction code, so the match index is the direction
  always_comb begin
    hit  = 1'b0;
    kdir = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (k_q == KEYS[i]) begin
        hit  = 1'b1;
        kdir = i[1:0];
      end
    end
  end

  always_comb begin
    lim = (state == S_HOLD) ? HOLD_LIM : REP_LIM;
    ev  = 1'b0;
    if (enable && hit) begin
      if (state == S_IDLE || kdir != cur_dir) ev = 1'b1;
      else if (frame_tick && cnt == lim)      ev = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= 6'd0;
      cur_dir <= 2'd0;
      valid   <= 1'b0;
      dir     <= 2'd0;
    end else if (!enable) begin
      state <= S_IDLE;
      cnt   <= 6'd0;
      valid <= 1'b0;
    end else begin
      if (!hit) begin
        state <= S_IDLE;
        cnt   <= 6'd0;
      end else if (state == S_IDLE || kdir != cur_dir) begin
        state   <= S_HOLD;
        cnt     <= 6'd0;
        cur_dir <= kdir;
      end else if (frame_tick) begin
        if (cnt == lim) begin
          state <= S_REPEAT;
          cnt   <= 6'd0;
        end else if (cnt != 6'd63) begin
          cnt <= cnt + 6'd1;
        end
      end
      // a full, stalled slot drops the event; the FSM above still advances
      if (ev && (!valid || ready)) begin
        valid <= 1'b1;
        dir   <= kdir;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end
endmodule

module keycode_move_ctrl #(
  parameter int HOLD_FRAMES   = 20,
  parameter int REPEAT_FRAMES = 8
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [7:0] keycode,
  input  logic       frame_tick,
  input  logic       enable,
  output logic       p1_valid,
  output logic [1:0] p1_dir,
  input  logic       p1_ready,
  output logic       p2_valid,
  output logic [1:0] p2_dir,
  input  logic       p2_ready
);
  localparam int NUM_PLAYERS = 2;

  // clamp to the 6-bit counter range so out-of-range values saturate
  function automatic logic [5:0] frames_to_lim(input int n);
    if (n <= 1)  return 6'd0;
    if (n >= 64) return 6'd63;
    return 6'(n - 1);
  endfunction

  localparam logic [5:0] HOLD_LIM = frames_to_lim(HOLD_FRAMES);
  localparam logic [5:0] REP_LIM  = frames_to_lim(REPEAT_FRAMES);

  // [player][dir]: dir 0 up, 1 down, 2 left, 3 right
  localparam logic [NUM_PLAYERS-1:0][3:0][7:0] KEYMAP = {
    {8'h4F, 8'h50, 8'h51, 8'h52},
    {8'h07, 8'h04, 8'h16, 8'h1A}
  };

  logic [7:0]                  k_q;
  logic [NUM_PLAYERS-1:0]      ready_v;
  logic [NUM_PLAYERS-1:0]      valid_v;
  logic [NUM_PLAYERS-1:0][1:0] dir_v;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) k_q <= 8'h00;
    else                k_q <= keycode;
  end

  assign ready_v = {p2_ready, p1_ready};

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
    keycode_move_player #(
      .KEYS    (KEYMAP[g]),
      .HOLD_LIM(HOLD_LIM),
      .REP_LIM (REP_LIM)
    ) u_player (
      .clk       (clk_clk),
      .rst_n     (reset_reset_n),
      .k_q       (k_q),
      .frame_tick(frame_tick),
      .enable    (enable),
      .ready     (ready_v[g]),
      .valid     (valid_v[g]),
      .dir       (dir_v[g])
    );
  end

  assign p1_valid = valid_v[0];
  assign p1_dir   = dir_v[0];
  assign p2_valid = valid_v[1];
  assign p2_dir   = dir_v[1];
endmodule

// File: tb/tb_keycode_move_ctrl.sv
// Bench for keycode_move_ctrl: press/hold-time model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.

module tb_keycode_move_ctrl;
  localparam int HF = 20;
  localparam int RF = 8;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n;
  logic [7:0] keycode;
  logic       frame_tick, enable;
  logic       p1_valid, p1_ready, p2_valid, p2_ready;
  logic [1:0] p1_dir, p2_dir;

  keycode_move_ctrl #(.HOLD_FRAMES(HF), .REPEAT_FRAMES(RF)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .keycode(keycode),
    .frame_tick(frame_tick), .enable(enable),
    .p1_valid(p1_valid), .p1_dir(p1_dir), .p1_ready(p1_ready),
    .p2_valid(p2_valid), .p2_dir(p2_dir), .p2_ready(p2_ready)
  );

  always #5 clk_clk = ~clk_clk;

  int n_chk = 0;
  int n_fail = 0;
  int cnt1 = 0;
  int cnt2 = 0;

  // model: per player, whether a press is active, its direction, ticks since
  // the press, and the output slot contents
  logic [7:0] kq_m;
  bit         m_act[2];
  logic [1:0] m_adir[2];
  int         m_ticks[2];
  bit         m_valid[2];
  logic [1:0] m_dir[2];

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void decode(input logic [7:0] k, output int p, output logic [1:0] d);
    p = -1; d = 2'd0;
    case (k)
      8'h1A: begin p = 0; d = 2'd0; end
      8'h16: begin p = 0; d = 2'd1; end
      8'h04: begin p = 0; d = 2'd2; end
      8'h07: begin p = 0; d = 2'd3; end
      8'h52: begin p = 1; d = 2'd0; end
      8'h51: begin p = 1; d = 2'd1; end
      8'h50: begin p = 1; d = 2'd2; end
      8'h4F: begin p = 1; d = 2'd3; end
      default: ;
    endcase
  endfunction

  task automatic model_reset();
    kq_m = 8'h00;
    for (int q = 0; q < 2; q++) begin
      m_act[q] = 0; m_adir[q] = 2'd0; m_ticks[q] = 0; m_valid[q] = 0; m_dir[q] = 2'd0;
    end
  endtask

  // advance the model by one clock edge using the input values about to be sampled
  task automatic model_step();
    int p;
    logic [1:0] d;
    bit ev, rdy;
    if (!reset_reset_n) begin
      model_reset();
      return;
    end
    decode(kq_m, p, d);
    for (int q = 0; q < 2; q++) begin
      ev = 0;
      if (!enable) begin
        m_act[q] = 0; m_valid[q] = 0;
      end else begin
        if (p != q) m_act[q] = 0;
        else if (!m_act[q] || d != m_adir[q]) begin
          ev = 1; m_act[q] = 1; m_adir[q] = d; m_ticks[q] = 0;
        end else if (frame_tick) begin
          m_ticks[q]++;
          if (m_ticks[q] == HF || (m_ticks[q] > HF && (m_ticks[q] - HF) % RF == 0)) ev = 1;
        end
        rdy = (q == 0) ? p1_ready : p2_ready;
        if (ev && (!m_valid[q] || rdy)) begin
          m_valid[q] = 1; m_dir[q] = d;
        end else if (m_valid[q] && rdy) m_valid[q] = 0;
      end
    end
    kq_m = keycode;
  endtask

  task automatic compare();
    check("p1_valid", int'(p1_valid), int'(m_valid[0]));
    check("p1_dir",   int'(p1_dir),   int'(m_dir[0]));
    check("p2_valid", int'(p2_valid), int'(m_valid[1]));
    check("p2_dir",   int'(p2_dir),   int'(m_dir[1]));
    if (p1_valid && p1_ready) cnt1++;
    if (p2_valid && p2_ready) cnt2++;
  endtask

  // compare at the falling edge, step the model, then return just after the rising edge
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk_clk);
      compare();
      model_step();
      @(posedge clk_clk);
      #1;
    end
  endtask

  initial begin
    reset_reset_n = 1'b0;
    keycode = 8'h00; frame_tick = 1'b0; enable = 1'b0;
    p1_ready = 1'b1; p2_ready = 1'b1;
    model_reset();
    #1;
    check("rst_p1_valid", int'(p1_valid), 0);
    check("rst_p2_valid", int'(p2_valid), 0);
    check("rst_p1_dir",   int'(p1_dir), 0);
    check("rst_p2_dir",   int'(p2_dir), 0);
    cyc(3);
    reset_reset_n = 1'b1;
    enable = 1'b1;
    cyc(2);

    // tap: one pulse on player 1 only
    cnt1 = 0; cnt2 = 0;
    keycode = 8'h1A; cyc(3);
    keycode = 8'h00; cyc(5);
    check("tap_p1_events", cnt1, 1);
    check("tap_p2_events", cnt2, 0);
    check("tap_p1_dir", int'(p1_dir), 0);

    // hold 0x4F for 36 ticks: press, tick 20, 28, 36
    cnt2 = 0;
    keycode = 8'h4F;
    for (int i = 0; i < 36; i++) begin
      cyc(9);
      frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
    end
    cyc(3);
    check("hold_p2_events", cnt2, 4);
    check("hold_p2_dir", int'(p2_dir), 3);
    keycode = 8'h00; cyc(3);

    // backpressure: second event dropped, then drained
    p1_ready = 1'b0;
    keycode = 8'h04; cyc(3);
    keycode = 8'h07; cyc(3);
    check("bp_valid", int'(p1_valid), 1);
    check("bp_dir", int'(p1_dir), 2);
    p1_ready = 1'b1; cyc(1);
    check("bp_drain", int'(p1_valid), 0);
    keycode = 8'h00; cyc(3);

    // direction change resets hold timing
    cnt2 = 0;
    keycode = 8'h51; cyc(2);
    for (int i = 0; i < 5; i++) begin
      frame_tick = 1'b1; cyc(1); frame_tick = 1'b0; cyc(3);
    end
    keycode = 8'h52; cyc(3);
    check("chg_dir", int'(p2_dir), 0);
    for (int i = 0; i < 19; i++) begin
      frame_tick = 1'b1; cyc(1); frame_tick = 1'b0; cyc(3);
    end
    check("chg_events_19", cnt2, 2);
    frame_tick = 1'b1; cyc(1); frame_tick = 1'b0; cyc(3);
    check("chg_events_20", cnt2, 3);
    keycode = 8'h00; cyc(3);

    // enable drop clears a pending slot; re-enable is a fresh press
    p1_ready = 1'b0;
    keycode = 8'h1A; cyc(3);
    check("en_pending", int'(p1_valid), 1);
    enable = 1'b0; cyc(1);
    check("en_drop", int'(p1_valid), 0);
    enable = 1'b1; cyc(1);
    check("en_repress", int'(p1_valid), 1);
    p1_ready = 1'b1; keycode = 8'h00; cyc(3);

    // reset mid-REPEAT
    keycode = 8'h16;
    for (int i = 0; i < 25; i++) begin
      frame_tick = 1'b1; cyc(1); frame_tick = 1'b0; cyc(1);
    end
    #2;
    reset_reset_n = 1'b0;
    model_reset();
    #1;
    check("mrst_p1_valid", int'(p1_valid), 0);
    check("mrst_p1_dir", int'(p1_dir), 0);
    check("mrst_p2_valid", int'(p2_valid), 0);
    cyc(2);
    reset_reset_n = 1'b1;
    cyc(1);
    check("mrst_kq_load", int'(p1_valid), 0);
    cyc(1);
    check("mrst_press", int'(p1_valid), 1);
    check("mrst_press_dir", int'(p1_dir), 1);
    keycode = 8'h00; cyc(3);

    // randomized traffic
    begin
      logic [7:0] keys[10] = '{8'h00, 8'h1A, 8'h16, 8'h04, 8'h07,
                               8'h52, 8'h51, 8'h50, 8'h4F, 8'h33};
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(39) == 0) keycode = keys[$urandom_range(9)];
        frame_tick = ($urandom_range(2) == 0);
        p1_ready = ($urandom_range(3) != 0);
        p2_ready = ($urandom_range(3) != 0);
        if ($urandom_range(149) == 0) enable = ~enable;
        cyc(1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
